// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned ImemAddrWidth = 10;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StVerify,
    StDone
  } loader_state_e;

endpackage

// File: rtl/imem_loader_addr_counter.sv
// Word-address walker: loads start/len, advances on step, wraps modulo memory depth.
module imem_loader_addr_counter #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] start_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic                  step_i,
  output logic [ADDR_WIDTH-1:0] cur_addr_o,
  output logic                  zero_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load_i) begin
      addr_d = start_i;
      rem_d  = len_i;
    end else if (step_i && (rem_q != '0)) begin
      addr_d = addr_q + 1'b1;
      rem_d  = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign cur_addr_o = addr_q;
  assign zero_o     = (rem_q == '0);
  assign last_o     = (rem_q == {{ADDR_WIDTH{1'b0}}, 1'b1});

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a host stream while fetch is held, then optionally boots.
// Define IMEM_LOADER_VERIFY_EN to add a read-back checksum pass before completion.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ImemAddrWidth,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic                  cmd_boot_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  imem_en_o,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [DATA_WIDTH-1:0] imem_data_w_o,
  input  logic [DATA_WIDTH-1:0] imem_data_r_i,
  output logic                  hold_fetch_o,
  output logic                  fetch_jump_o,
  output logic [ADDR_WIDTH-1:0] fetch_new_pc_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   words_written_o
);

  localparam logic [ADDR_WIDTH:0] MaxLen = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  boot_q, boot_d;
  logic [ADDR_WIDTH:0]   ww_q, ww_d;
  logic                  err_q, err_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] wr_chk_q, wr_chk_d;

  logic                  cnt_load, cnt_step, cnt_zero, cnt_last;
  logic [ADDR_WIDTH-1:0] cnt_start, cnt_addr;
  logic [ADDR_WIDTH:0]   cnt_len;
  logic                  rd_en;
  logic                  verify_err;

`ifdef IMEM_LOADER_VERIFY_EN
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_chk_q, rd_chk_d;
`endif

  imem_loader_addr_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_counter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (cnt_load),
    .start_i   (cnt_start),
    .len_i     (cnt_len),
    .step_i    (cnt_step),
    .cur_addr_o(cnt_addr),
    .zero_o    (cnt_zero),
    .last_o    (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    boot_d       = boot_q;
    ww_d         = ww_q;
    err_d        = 1'b0;
    wr_pend_d    = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_chk_d     = wr_chk_q;
    cnt_load     = 1'b0;
    cnt_start    = cmd_addr_i;
    cnt_len      = cmd_len_i;
    cnt_step     = 1'b0;
    rd_en        = 1'b0;
    cmd_ready_o  = 1'b0;
    data_ready_o = 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
    rd_valid_d   = 1'b0;
    rd_chk_d     = rd_valid_q ? (rd_chk_q ^ imem_data_r_i) : rd_chk_q;
`endif
    if (wr_pend_q) ww_d = ww_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          addr_d   = cmd_addr_i;
          len_d    = cmd_len_i;
          boot_d   = cmd_boot_i;
          ww_d     = '0;
          wr_chk_d = '0;
`ifdef IMEM_LOADER_VERIFY_EN
          rd_chk_d = '0;
`endif
          if (cmd_len_i > MaxLen) begin
            err_d = 1'b1;
          end else if (cmd_len_i == '0) begin
            state_d = StDone;
          end else begin
            cnt_load = 1'b1;
            state_d  = StWrite;
          end
        end
      end
      StWrite: begin
        data_ready_o = !cnt_zero;
        if (data_valid_i && !cnt_zero) begin
          wr_pend_d = 1'b1;
          wr_addr_d = cnt_addr;
          wr_data_d = data_i;
          wr_chk_d  = wr_chk_q ^ data_i;
          cnt_step  = 1'b1;
          if (cnt_last) begin
`ifdef IMEM_LOADER_VERIFY_EN
            // Rewind the walker for read-back; reads start once the final write drains.
            cnt_load  = 1'b1;
            cnt_start = addr_q;
            cnt_len   = len_q;
            state_d   = StVerify;
`else
            state_d   = StDone;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_VERIFY_EN
      StVerify: begin
        if (!wr_pend_q) begin
          rd_en      = 1'b1;
          rd_valid_d = 1'b1;
          cnt_step   = 1'b1;
          if (cnt_last) state_d = StDone;
        end
      end
`endif
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      boot_q     <= 1'b0;
      ww_q       <= '0;
      err_q      <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_chk_q   <= '0;
`ifdef IMEM_LOADER_VERIFY_EN
      rd_valid_q <= 1'b0;
      rd_chk_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      boot_q     <= boot_d;
      ww_q       <= ww_d;
      err_q      <= err_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_chk_q   <= wr_chk_d;
`ifdef IMEM_LOADER_VERIFY_EN
      rd_valid_q <= rd_valid_d;
      rd_chk_q   <= rd_chk_d;
`endif
    end
  end

`ifdef IMEM_LOADER_VERIFY_EN
  // The last read returns during DONE, so fold it in combinationally there.
  assign verify_err = (state_q == StDone) &&
                      ((rd_chk_q ^ (rd_valid_q ? imem_data_r_i : '0)) != wr_chk_q);
`else
  logic unused_verify;
  assign unused_verify = ^{imem_data_r_i, len_q};
  assign verify_err    = 1'b0;
`endif

  assign imem_en_o       = wr_pend_q | rd_en;
  assign imem_we_o       = wr_pend_q;
  assign imem_addr_o     = wr_pend_q ? wr_addr_q : (rd_en ? cnt_addr : '0);
  assign imem_data_w_o   = wr_pend_q ? wr_data_q : '0;
  assign hold_fetch_o    = (state_q != StIdle);
  assign done_o          = (state_q == StDone);
  assign err_o           = err_q | (done_o & verify_err);
  assign fetch_jump_o    = done_o & boot_q & !verify_err;
  assign fetch_new_pc_o  = fetch_jump_o ? addr_q : '0;
  assign words_written_o = ww_q;

endmodule
